dmem_arbiter: RTL

- Shares the single byte-addressed data memory (word port, big-endian byte order handled inside the memory) between the MIPS CPU load/store path and a DMA/debug loader port.
- CPU has priority. A starvation counter guarantees DMA forward progress.
- Generates the CPU stall signal and routes the 1-cycle-latency read data back to the winning requester.
- Sits between the CPU datapath and the DM instance.

---
 rtl/dmem_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single word-wide data memory between the CPU
// load/store path and a DMA/debug loader port.
//
// The CPU has priority. A starvation counter forces a DMA win after
// STARVE_MAX consecutive losing cycles. The block generates the CPU stall
// and routes the 1-cycle-latency read data back to whichever port issued
// the read.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   cpu_req/we/addr/wdata            CPU request (held until cpu_gnt)
//   cpu_gnt, cpu_stall               CPU accept / stall (req && !gnt)
//   cpu_rvalid, cpu_rdata            CPU load return
//   dma_req/we/addr/wdata            DMA request (held until dma_gnt)
//   dma_gnt                          DMA accept
//   dma_rvalid, dma_rdata            DMA read return
//   mem_en/we/addr/wdata, mem_rdata  data memory port
//   misalign_err                     pulse one cycle after a misaligned grant
module dmem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          misalign_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_e;

    logic [SW-1:0] starve_cnt;
    logic          rd_pend;
    owner_e        rd_owner;
    logic [DW-1:0] cpu_rdata_q, dma_rdata_q;
    logic          force_dma, granted, aligned, win_we;

    // Arbitration and memory mux. Grants are masked while reset is held so
    // that no access can leak to memory during reset.
    always_comb begin
        force_dma = dma_req && (starve_cnt == SMAX);
        cpu_gnt   = rst_n && cpu_req && !force_dma;
        dma_gnt   = rst_n && dma_req && (!cpu_req || force_dma);
        cpu_stall = cpu_req && !cpu_gnt;
        granted   = cpu_gnt || dma_gnt;
        mem_addr  = dma_gnt ? dma_addr  : cpu_addr;
        mem_wdata = dma_gnt ? dma_wdata : cpu_wdata;
        win_we    = dma_gnt ? dma_we    : cpu_we;
        aligned   = (mem_addr[1:0] == 2'b00);
        // Misaligned grants complete the handshake but never reach memory.
        mem_en    = granted && aligned;
        mem_we    = granted && win_we;
    end

    // Return path: the owner sees memory data directly in the return cycle;
    // the captured copy keeps each port's rdata stable between its returns.
    always_comb begin
        cpu_rvalid = rd_pend && (rd_owner == OWN_CPU);
        dma_rvalid = rd_pend && (rd_owner == OWN_DMA);
        cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
        dma_rdata  = dma_rvalid ? mem_rdata : dma_rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt   <= '0;
            rd_pend      <= 1'b0;
            rd_owner     <= OWN_CPU;
            misalign_err <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            if (!dma_req || dma_gnt)
                starve_cnt <= '0;
            else if (starve_cnt != SMAX)
                starve_cnt <= starve_cnt + SW'(1);

            rd_pend      <= mem_en && !win_we;
            misalign_err <= granted && !aligned;
            if (mem_en && !win_we)
                rd_owner <= dma_gnt ? OWN_DMA : OWN_CPU;

            if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
            if (dma_rvalid) dma_rdata_q <= mem_rdata;
        end
    end

endmodule
